logicshifter_deadtime_ctrl: RTL and testbench
=============================================

LOGICSHIFTER_DEADTIME_CTRL -- requirements
Module: logicshifter_deadtime_ctrl

Interface
REQ-001 Parameter NPAIR, default 2, number of top/bottom FET shifter pairs (1..8).
REQ-002 Parameter DT_CYC, default 4, break-before-make dead time in clock cycles (>=1).
REQ-003 Parameter WARM_CYC, default 16, shifter warm-up cycles after enable before data passes (>=1).
REQ-004 Parameter FILT_CYC, default 2, pwm_in glitch-filter length in cycles (>=1).
REQ-005 CELCLK  in  1  sole clock; all state updates on its rising edge.
REQ-006 CELRST  in  1  reset, synchronous, active-high.
REQ-007 enable  in  1  block enable from low-voltage logic.
REQ-008 pwm_in  in  NPAIR  per-pair drive request; 1 = top on, 0 = bottom on.
REQ-009 fault  in  1  external fault (overcurrent/UVLO), level-sensitive.
REQ-010 fault_clr  in  1  single-cycle fault-latch clear request.
REQ-011 enable_logicshifter  out  1  common enable to all level shifters.
REQ-012 top_in  out  NPAIR  data to top-switch shifter of each pair.
REQ-013 bot_in  out  NPAIR  data to bottom-switch shifter of each pair.
REQ-014 ready  out  1  high while pairs follow pwm_in.
REQ-015 fault_latched  out  1  high while fault latch is set.

Function
REQ-016 Global FSM states OFF, WARM, RUN, FAULT; all outputs registered.
REQ-017 OFF->WARM when enable=1 and fault=0; WARM->RUN after WARM_CYC cycles in WARM; WARM/RUN->OFF when enable=0.
REQ-018 fault=1 in any state -> FAULT next edge, priority over enable; FAULT->OFF only when fault_clr=1 and fault=0 same cycle; fault_clr ignored otherwise.
REQ-019 enable_logicshifter=1 in WARM and RUN only; ready=1 in RUN only; fault_latched=1 in FAULT only.
REQ-020 Outside RUN all top_in/bot_in=0, and pair FSMs/dead counters held in IDLE.
REQ-021 Per-pair filter: filtered value (reset 0) takes new pwm_in value on the edge sampling the FILT_CYC-th consecutive differing sample; any reversion restarts the count.
REQ-022 Per-pair FSM IDLE, TOP, BOT, DEAD; IDLE->TOP if filtered=1 else BOT, on first RUN edge.
REQ-023 TOP with filtered=0, or BOT with filtered=1 -> DEAD; both outputs 0 in DEAD.
REQ-024 DEAD lasts exactly DT_CYC cycles regardless of filtered changes; exit to TOP if filtered=1 else BOT, sampled on exit edge.
REQ-025 top_in=1 only in TOP, bot_in=1 only in BOT; top_in[i]&bot_in[i]=0 always.
REQ-026 After any output falls, the complementary output of that pair stays 0 >= DT_CYC cycles.
REQ-027 Latency from filtered change in TOP/BOT: driven side 0 next edge, opposite side 1 DT_CYC edges later.
REQ-028 Leaving RUN (enable drop or fault) zeroes all pair outputs on the same edge the global state changes.
REQ-029 Counters sized $clog2(max+1); no wrap; saturate at terminal count.

Reset
REQ-030 CELRST=1: global OFF, pairs IDLE, filters 0, counters 0, all outputs 0, including mid-DEAD or mid-WARM.
REQ-031 CELRST overrides fault; after release FSM re-enters FAULT if fault still 1.

Structure
REQ-032 Shared package logicshifter_pkg holds global/pair state enums and default parameter constants.
REQ-033 One sub-module logicshifter_pair_deadtime (filter + pair FSM + dead counter), instantiated NPAIR times.

Verification
REQ-034 Reset, enable=1, pwm_in=0: enable_logicshifter=1 next edge, ready and bot_in=11 after 16 WARM cycles (+1 edge for pair).
REQ-035 RUN, pwm_in[0] 0->1 held: bot_in[0] falls 2 edges later (filter) +1, top_in[0] rises exactly 4 edges after fall.
REQ-036 RUN, pwm_in[1] 1-cycle glitch: no change on top_in[1]/bot_in[1].
REQ-037 pwm_in[0] toggles back mid-DEAD: DEAD still 4 cycles, returns to original side, overlap never observed.
REQ-038 fault pulse in RUN: all outputs 0 next edge, fault_latched=1; fault_clr with fault=1 ignored; fault_clr with fault=0 -> OFF.
REQ-039 CELRST asserted mid-DEAD and mid-WARM: all outputs 0 next edge; random pwm_in soak checks REQ-025/026 assertions.

Source files
------------

// File: rtl/logicshifter_pkg.sv
// Shared state encodings and default timing constants for the level-shifter dead-time controller.
package logicshifter_pkg;

  typedef enum logic [1:0] {
    G_OFF,
    G_WARM,
    G_RUN,
    G_FAULT
  } gstate_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_TOP,
    P_BOT,
    P_DEAD
  } pstate_e;

  localparam int NPAIR_DEF    = 2;
  localparam int DT_CYC_DEF   = 4;
  localparam int WARM_CYC_DEF = 16;
  localparam int FILT_CYC_DEF = 2;

endpackage

// File: rtl/logicshifter_pair_deadtime.sv
// One top/bottom pair: pwm glitch filter, break-before-make FSM and dead counter.
// Registered outputs; the driven side drops one edge after a filtered change, the other rises DT_CYC edges later.
module logicshifter_pair_deadtime
  import logicshifter_pkg::*;
#(
  parameter int DT_CYC   = DT_CYC_DEF,
  parameter int FILT_CYC = FILT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic pwm_i,
  output logic top_o,
  output logic bot_o
);

  localparam int FW = $clog2(FILT_CYC + 1);
  localparam int DW = $clog2(DT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYC - 1);
  localparam logic [DW-1:0] DT_LAST   = DW'(DT_CYC - 1);

  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  pstate_e       state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          top_q, bot_q;

  // Filter keeps running outside RUN so the pair starts on a settled value.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (pwm_i != filt_q) begin
      if (fcnt_q >= FILT_LAST) begin
        filt_d = pwm_i;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = '0;
    if (!run_i) begin
      state_d = P_IDLE;
    end else begin
      case (state_q)
        P_IDLE: state_d = filt_q ? P_TOP : P_BOT;
        P_TOP:  if (!filt_q) state_d = P_DEAD;
        P_BOT:  if (filt_q) state_d = P_DEAD;
        P_DEAD: begin
          // Dead time is fixed length; the exit side is decided only on the exit edge.
          if (dcnt_q >= DT_LAST) begin
            state_d = filt_q ? P_TOP : P_BOT;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: state_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q  <= 1'b0;
      fcnt_q  <= '0;
      state_q <= P_IDLE;
      dcnt_q  <= '0;
      top_q   <= 1'b0;
      bot_q   <= 1'b0;
    end else begin
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      top_q   <= (state_d == P_TOP);
      bot_q   <= (state_d == P_BOT);
    end
  end

  assign top_o = top_q;
  assign bot_o = bot_q;

endmodule

// File: rtl/logicshifter_deadtime_ctrl.sv
// Global OFF/WARM/RUN/FAULT sequencer for a bank of FET level-shifter pairs with dead-time insertion.
// All outputs registered; pairs start one edge after RUN is reached and drop on the edge RUN is left.
module logicshifter_deadtime_ctrl
  import logicshifter_pkg::*;
#(
  parameter int NPAIR    = NPAIR_DEF,
  parameter int DT_CYC   = DT_CYC_DEF,
  parameter int WARM_CYC = WARM_CYC_DEF,
  parameter int FILT_CYC = FILT_CYC_DEF
) (
  input  logic             CELCLK,
  input  logic             CELRST,
  input  logic             enable,
  input  logic [NPAIR-1:0] pwm_in,
  input  logic             fault,
  input  logic             fault_clr,
  output logic             enable_logicshifter,
  output logic [NPAIR-1:0] top_in,
  output logic [NPAIR-1:0] bot_in,
  output logic             ready,
  output logic             fault_latched
);

  localparam int WW = $clog2(WARM_CYC + 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARM_CYC - 1);

  gstate_e       state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          en_q, rdy_q, flt_q;
  logic          pair_run;

  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = G_FAULT;
    end else begin
      case (state_q)
        G_OFF:   if (enable) state_d = G_WARM;
        G_WARM: begin
          if (!enable) begin
            state_d = G_OFF;
          end else if (wcnt_q >= WARM_LAST) begin
            state_d = G_RUN;
          end
        end
        G_RUN:   if (!enable) state_d = G_OFF;
        G_FAULT: if (fault_clr) state_d = G_OFF;
        default: state_d = G_OFF;
      endcase
    end
  end

  always_comb begin
    wcnt_d = '0;
    if (state_q == G_WARM && state_d == G_WARM) begin
      wcnt_d = (wcnt_q < WARM_LAST) ? wcnt_q + 1'b1 : wcnt_q;
    end
  end

  // Looking at state_d lets the pairs drop on the same edge that RUN is left.
  assign pair_run = (state_q == G_RUN) && (state_d == G_RUN);

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state_q <= G_OFF;
      wcnt_q  <= '0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      en_q    <= (state_d == G_WARM) || (state_d == G_RUN);
      rdy_q   <= (state_d == G_RUN);
      flt_q   <= (state_d == G_FAULT);
    end
  end

  for (genvar g = 0; g < NPAIR; g++) begin : g_pair
    logicshifter_pair_deadtime #(
      .DT_CYC  (DT_CYC),
      .FILT_CYC(FILT_CYC)
    ) u_pair (
      .clk_i(CELCLK),
      .rst_i(CELRST),
      .run_i(pair_run),
      .pwm_i(pwm_in[g]),
      .top_o(top_in[g]),
      .bot_o(bot_in[g])
    );
  end

  assign enable_logicshifter = en_q;
  assign ready               = rdy_q;
  assign fault_latched       = flt_q;

endmodule

// File: tb/tb_logicshifter_deadtime_ctrl.sv
// Directed bench for logicshifter_deadtime_ctrl at default parameters, plus a random pwm soak
// watched by an overlap / dead-gap monitor.
module tb_logicshifter_deadtime_ctrl;

  localparam int NP = 2;
  localparam int DT = 4;

  logic          CELCLK;
  logic          CELRST;
  logic          enable;
  logic [NP-1:0] pwm_in;
  logic          fault;
  logic          fault_clr;
  logic          enable_logicshifter;
  logic [NP-1:0] top_in;
  logic [NP-1:0] bot_in;
  logic          ready;
  logic          fault_latched;

  int n_vec = 0;
  int n_mis = 0;
  int viol  = 0;
  int act   = 0;
  int act0  = 0;
  int tgap [NP] = '{default: 1000};
  int bgap [NP] = '{default: 1000};
  logic [NP-1:0] tprev = '0;
  logic [NP-1:0] bprev = '0;

  logicshifter_deadtime_ctrl dut (
    .CELCLK             (CELCLK),
    .CELRST             (CELRST),
    .enable             (enable),
    .pwm_in             (pwm_in),
    .fault              (fault),
    .fault_clr          (fault_clr),
    .enable_logicshifter(enable_logicshifter),
    .top_in             (top_in),
    .bot_in             (bot_in),
    .ready              (ready),
    .fault_latched      (fault_latched)
  );

  initial CELCLK = 1'b0;
  always #5 CELCLK = ~CELCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CELCLK);
    #1;
  endtask

  function automatic logic [2:0] glob();
    return {enable_logicshifter, ready, fault_latched};
  endfunction

  function automatic logic [3:0] pairs();
    return {top_in, bot_in};
  endfunction

  // Overlap and break-before-make gap monitor, sampled away from the active edge.
  always @(negedge CELCLK) begin
    for (int i = 0; i < NP; i++) begin
      if (top_in[i] && bot_in[i]) viol++;
      if (tprev[i] && !top_in[i]) tgap[i] = 0;
      else if (tgap[i] < 1000) tgap[i]++;
      if (bprev[i] && !bot_in[i]) bgap[i] = 0;
      else if (bgap[i] < 1000) bgap[i]++;
      if (!bprev[i] && bot_in[i] && tgap[i] < DT) viol++;
      if (!tprev[i] && top_in[i]) begin
        act++;
        if (bgap[i] < DT) viol++;
      end
    end
    tprev = top_in;
    bprev = bot_in;
  end

  initial begin
    CELRST = 1'b1; enable = 1'b0; pwm_in = '0; fault = 1'b0; fault_clr = 1'b0;
    tick(3);
    check("rst_glob", 32'(glob()), 32'h0);
    check("rst_pair", 32'(pairs()), 32'h0);

    // Warm-up from OFF with pwm_in = 00
    CELRST = 1'b0; enable = 1'b1;
    tick(1);  check("warm_en", 32'(glob()), 32'b100);
    tick(15); check("warm_end", 32'(glob()), 32'b100);
    check("warm_pair", 32'(pairs()), 32'h0);
    tick(1);  check("run_rdy", 32'(glob()), 32'b110);
    check("run_pair_idle", 32'(pairs()), 32'b0000);
    tick(1);  check("run_bot", 32'(pairs()), 32'b0011);

    // pair0 0->1: filter 2 edges, drop on 3rd, top after DT
    pwm_in = 2'b01;
    tick(2); check("filt_hold", 32'(pairs()), 32'b0011);
    tick(1); check("bot0_fall", 32'(pairs()), 32'b0010);
    tick(3); check("dead0", 32'(pairs()), 32'b0010);
    tick(1); check("top0_rise", 32'(pairs()), 32'b0110);

    // one-cycle glitch on pair1
    pwm_in = 2'b11;
    tick(1); pwm_in = 2'b01;
    tick(4); check("glitch1", 32'(pairs()), 32'b0110);

    // pair0 reverts mid-DEAD: still full dead time, back to top
    pwm_in = 2'b00;
    tick(2); check("top0_hold", 32'(pairs()), 32'b0110);
    tick(1); check("top0_fall", 32'(pairs()), 32'b0010);
    pwm_in = 2'b01;
    tick(3); check("dead_rev", 32'(pairs()), 32'b0010);
    tick(1); check("dead_exit_top", 32'(pairs()), 32'b0110);

    // fault handling
    fault = 1'b1;
    tick(1); check("flt_glob", 32'(glob()), 32'b001);
    check("flt_pair", 32'(pairs()), 32'h0);
    fault = 1'b0;
    tick(1); check("flt_hold", 32'(glob()), 32'b001);
    fault = 1'b1; fault_clr = 1'b1;
    tick(1); check("clr_ign", 32'(glob()), 32'b001);
    fault = 1'b0;
    tick(1); check("clr_off", 32'(glob()), 32'b000);
    fault_clr = 1'b0;
    tick(1);  check("rewarm", 32'(glob()), 32'b100);
    tick(16); check("rerun", 32'(glob()), 32'b110);
    check("rerun_idle", 32'(pairs()), 32'h0);
    tick(1);  check("rerun_pair", 32'(pairs()), 32'b0110);

    // enable drop in RUN
    enable = 1'b0;
    tick(1); check("dis_glob", 32'(glob()), 32'h0);
    check("dis_pair", 32'(pairs()), 32'h0);

    // reset mid-WARM
    enable = 1'b1;
    tick(6); check("mw_glob", 32'(glob()), 32'b100);
    CELRST = 1'b1;
    tick(1); check("mw_rst", 32'(glob()), 32'h0);
    CELRST = 1'b0;
    tick(1); check("mw_rel", 32'(glob()), 32'b100);

    // reset overrides fault; fault re-enters after release
    CELRST = 1'b1; fault = 1'b1;
    tick(1); check("rst_vs_flt", 32'(glob()), 32'h0);
    CELRST = 1'b0;
    tick(1); check("flt_after_rst", 32'(glob()), 32'b001);
    fault = 1'b0; fault_clr = 1'b1;
    tick(1); fault_clr = 1'b0;
    tick(17); check("run2", 32'(glob()), 32'b110);
    tick(1);  check("run2_pair", 32'(pairs()), 32'b0110);

    // both pairs swap, reset while both are in DEAD
    pwm_in = 2'b10;
    tick(3); check("both_dead", 32'(pairs()), 32'h0);
    tick(1);
    CELRST = 1'b1;
    tick(1); check("md_rst_pair", 32'(pairs()), 32'h0);
    check("md_rst_glob", 32'(glob()), 32'h0);
    CELRST = 1'b0;
    tick(18); check("md_restart", 32'(pairs()), 32'b1001);

    // random soak
    act0 = act;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) pwm_in = 2'($urandom_range(0, 3));
      tick(1);
    end
    check("soak_rules", 32'(viol), 32'h0);
    check("soak_act", 32'(act > act0 + 10), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
